// File: rtl/mmu_tlb_if.sv
// rtl/mmu_tlb_if.sv - lookup, CP0 TLB-op and result bundle for mmu_tlb
interface mmu_tlb_if #(
  parameter int IDX_W  = 4,
  parameter int ASID_W = 8
);
  logic              inst_req;
  logic [31:0]       inst_vaddr;
  logic              data_req;
  logic [31:0]       data_vaddr;
  logic              data_we;
  logic              user_mode;
  logic              cp0_kseg0_uncached;
  logic [ASID_W-1:0] asid;
  logic [IDX_W-1:0]  wired;
  logic              tlb_op_valid;
  logic [1:0]        tlb_op;
  logic [IDX_W-1:0]  index_i;
  logic [31:0]       entryhi_i;
  logic [31:0]       entrylo0_i;
  logic [31:0]       entrylo1_i;

  logic              inst_valid, inst_uncached, inst_miss, inst_inval, inst_illegal;
  logic [31:0]       inst_paddr;
  logic              data_valid, data_uncached, data_miss, data_inval, data_modify, data_illegal;
  logic [31:0]       data_paddr;
  logic              tlb_op_done;
  logic              probe_fail;
  logic [IDX_W-1:0]  probe_index;
  logic [31:0]       entryhi_o, entrylo0_o, entrylo1_o;
  logic [IDX_W-1:0]  random_o;

  modport master (
    output inst_req, inst_vaddr, data_req, data_vaddr, data_we, user_mode,
           cp0_kseg0_uncached, asid, wired, tlb_op_valid, tlb_op, index_i,
           entryhi_i, entrylo0_i, entrylo1_i,
    input  inst_valid, inst_uncached, inst_miss, inst_inval, inst_illegal, inst_paddr,
           data_valid, data_uncached, data_miss, data_inval, data_modify, data_illegal,
           data_paddr, tlb_op_done, probe_fail, probe_index, entryhi_o, entrylo0_o,
           entrylo1_o, random_o
  );

  modport slave (
    input  inst_req, inst_vaddr, data_req, data_vaddr, data_we, user_mode,
           cp0_kseg0_uncached, asid, wired, tlb_op_valid, tlb_op, index_i,
           entryhi_i, entrylo0_i, entrylo1_i,
    output inst_valid, inst_uncached, inst_miss, inst_inval, inst_illegal, inst_paddr,
           data_valid, data_uncached, data_miss, data_inval, data_modify, data_illegal,
           data_paddr, tlb_op_done, probe_fail, probe_index, entryhi_o, entrylo0_o,
           entrylo1_o, random_o
  );
endinterface

// File: rtl/mmu_tlb.sv
// rtl/mmu_tlb.sv - kseg0/kseg1 direct map plus fully-associative ASID-tagged TLB
// with registered parallel instruction/data lookup and CP0 TLBWI/TLBWR/TLBP/TLBR.
module mmu_tlb #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int ASID_W      = 8
) (
  input logic      clk,
  input logic      rst,
  mmu_tlb_if.slave bus
);
  typedef struct packed {
    logic        uncached;
    logic        miss;
    logic        inval;
    logic        modify;
    logic        illegal;
    logic [31:0] paddr;
  } xlat_t;

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_ENTRIES - 1);

  logic [18:0]       vpn2  [NUM_ENTRIES];
  logic [ASID_W-1:0] easid [NUM_ENTRIES];
  logic              g     [NUM_ENTRIES];
  logic [19:0]       pfn0  [NUM_ENTRIES];
  logic [19:0]       pfn1  [NUM_ENTRIES];
  logic [2:0]        c0    [NUM_ENTRIES];
  logic [2:0]        c1    [NUM_ENTRIES];
  logic              d0    [NUM_ENTRIES];
  logic              d1    [NUM_ENTRIES];
  logic              v0    [NUM_ENTRIES];
  logic              v1    [NUM_ENTRIES];
  logic [IDX_W-1:0]  rand_q;

  // Returns {hit, index}; scanning downward leaves the lowest matching index.
  function automatic logic [IDX_W:0] match(input logic [18:0] vpn, input logic [ASID_W-1:0] a);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (vpn2[i] == vpn && (g[i] || easid[i] == a)) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  function automatic xlat_t xlate(input logic [31:0] va, input logic we, input logic um,
                                  input logic k0u, input logic [ASID_W-1:0] a);
    xlat_t            r;
    logic [IDX_W:0]   m;
    logic [IDX_W-1:0] k;
    logic             odd;
    r   = '0;
    m   = match(va[31:13], a);
    k   = m[IDX_W-1:0];
    odd = va[12];
    if (um && va[31]) begin
      r.illegal = 1'b1;
    end else if (va[31:30] == 2'b10) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = va[29] | k0u;
    end else if (!m[IDX_W]) begin
      r.miss = 1'b1;
    end else if (!(odd ? v1[k] : v0[k])) begin
      r.inval = 1'b1;
    end else begin
      r.paddr    = {(odd ? pfn1[k] : pfn0[k]), va[11:0]};
      r.uncached = (odd ? c1[k] : c0[k]) == 3'd2;
      r.modify   = we & !(odd ? d1[k] : d0[k]);
    end
    return r;
  endfunction

  xlat_t            inst_x, data_x;
  logic [IDX_W:0]   probe_m;
  logic [31:0]      rd_hi, rd_lo0, rd_lo1;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  always_comb begin
    inst_x  = xlate(bus.inst_vaddr, 1'b0, bus.user_mode, bus.cp0_kseg0_uncached, bus.asid);
    data_x  = xlate(bus.data_vaddr, bus.data_we, bus.user_mode, bus.cp0_kseg0_uncached, bus.asid);
    probe_m = match(bus.entryhi_i[31:13], bus.entryhi_i[ASID_W-1:0]);
    wr_en   = bus.tlb_op_valid && !bus.tlb_op[1];
    wr_idx  = bus.tlb_op[0] ? rand_q : bus.index_i;
    rd_hi   = '0;
    rd_lo0  = '0;
    rd_lo1  = '0;
    rd_hi[31:13]       = vpn2[bus.index_i];
    rd_hi[ASID_W-1:0]  = easid[bus.index_i];
    rd_lo0[25:0]       = {pfn0[bus.index_i], c0[bus.index_i], d0[bus.index_i], v0[bus.index_i], g[bus.index_i]};
    rd_lo1[25:0]       = {pfn1[bus.index_i], c1[bus.index_i], d1[bus.index_i], v1[bus.index_i], g[bus.index_i]};
  end

  logic unused_bits;
  assign unused_bits = ^{bus.entryhi_i[12:ASID_W], bus.entrylo0_i[31:26], bus.entrylo1_i[31:26]};

  assign bus.random_o = rand_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        vpn2[i] <= '0; easid[i] <= '0; g[i] <= 1'b0;
        pfn0[i] <= '0; pfn1[i] <= '0; c0[i] <= '0; c1[i] <= '0;
        d0[i] <= 1'b0; d1[i] <= 1'b0; v0[i] <= 1'b0; v1[i] <= 1'b0;
      end
      rand_q            <= TOP_IDX;
      bus.inst_valid    <= 1'b0; bus.inst_uncached <= 1'b0; bus.inst_miss <= 1'b0;
      bus.inst_inval    <= 1'b0; bus.inst_illegal  <= 1'b0; bus.inst_paddr <= '0;
      bus.data_valid    <= 1'b0; bus.data_uncached <= 1'b0; bus.data_miss <= 1'b0;
      bus.data_inval    <= 1'b0; bus.data_modify   <= 1'b0; bus.data_illegal <= 1'b0;
      bus.data_paddr    <= '0;
      bus.tlb_op_done   <= 1'b0; bus.probe_fail <= 1'b0; bus.probe_index <= '0;
      bus.entryhi_o     <= '0; bus.entrylo0_o <= '0; bus.entrylo1_o <= '0;
    end else begin
      if (wr_en) begin
        vpn2[wr_idx]  <= bus.entryhi_i[31:13];
        easid[wr_idx] <= bus.entryhi_i[ASID_W-1:0];
        g[wr_idx]     <= bus.entrylo0_i[0] & bus.entrylo1_i[0];
        pfn0[wr_idx]  <= bus.entrylo0_i[25:6]; pfn1[wr_idx] <= bus.entrylo1_i[25:6];
        c0[wr_idx]    <= bus.entrylo0_i[5:3];  c1[wr_idx]   <= bus.entrylo1_i[5:3];
        d0[wr_idx]    <= bus.entrylo0_i[2];    d1[wr_idx]   <= bus.entrylo1_i[2];
        v0[wr_idx]    <= bus.entrylo0_i[1];    v1[wr_idx]   <= bus.entrylo1_i[1];
      end
      if ((wr_en && bus.tlb_op[0]) || rand_q <= bus.wired) rand_q <= TOP_IDX;
      else                                                 rand_q <= rand_q - 1'b1;

      // Result flags/paddr hold their last value while a channel is idle.
      bus.inst_valid <= bus.inst_req;
      if (bus.inst_req) begin
        bus.inst_uncached <= inst_x.uncached; bus.inst_miss    <= inst_x.miss;
        bus.inst_inval    <= inst_x.inval;    bus.inst_illegal <= inst_x.illegal;
        bus.inst_paddr    <= inst_x.paddr;
      end
      bus.data_valid <= bus.data_req;
      if (bus.data_req) begin
        bus.data_uncached <= data_x.uncached; bus.data_miss    <= data_x.miss;
        bus.data_inval    <= data_x.inval;    bus.data_modify  <= data_x.modify;
        bus.data_illegal  <= data_x.illegal;  bus.data_paddr   <= data_x.paddr;
      end

      bus.tlb_op_done <= bus.tlb_op_valid && bus.tlb_op[1];
      if (bus.tlb_op_valid && bus.tlb_op == 2'd2) begin
        bus.probe_fail  <= !probe_m[IDX_W];
        bus.probe_index <= probe_m[IDX_W-1:0];
      end
      if (bus.tlb_op_valid && bus.tlb_op == 2'd3) begin
        bus.entryhi_o  <= rd_hi;
        bus.entrylo0_o <= rd_lo0;
        bus.entrylo1_o <= rd_lo1;
      end
    end
  end
endmodule

// File: tb/tb_mmu_tlb.sv
// tb/tb_mmu_tlb.sv - scoreboard bench for mmu_tlb lookups and CP0 TLB ops
module tb_mmu_tlb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmu_tlb_if #(.IDX_W(4), .ASID_W(8)) bus();
  mmu_tlb #(.NUM_ENTRIES(16), .IDX_W(4), .ASID_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  // flags = {illegal, miss, inval, modify, uncached}
  typedef struct packed { logic [4:0] flags; logic [31:0] paddr; } lk_e;
  typedef struct packed { logic is_rd; logic [31:0] a; logic [31:0] b; logic [31:0] c; } op_e;

  localparam logic [4:0] F_ILL = 5'b10000, F_MISS = 5'b01000, F_INV = 5'b00100,
                         F_MOD = 5'b00010, F_UC = 5'b00001, F_OK = 5'b00000;
  localparam logic [1:0] OP_WI = 2'd0, OP_WR = 2'd1, OP_P = 2'd2, OP_R = 2'd3;

  lk_e iq[$];
  lk_e dq[$];
  op_e oq[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ireq(input logic [31:0] va, input logic [4:0] f, input logic [31:0] pa);
    bus.inst_req = 1'b1; bus.inst_vaddr = va;
    iq.push_back('{flags: f, paddr: pa});
  endtask

  task automatic dreq(input logic [31:0] va, input logic we, input logic [4:0] f, input logic [31:0] pa);
    bus.data_req = 1'b1; bus.data_vaddr = va; bus.data_we = we;
    dq.push_back('{flags: f, paddr: pa});
  endtask

  task automatic op(input logic [1:0] o, input logic [3:0] idx, input logic [31:0] hi,
                    input logic [31:0] lo0, input logic [31:0] lo1);
    bus.tlb_op_valid = 1'b1; bus.tlb_op = o; bus.index_i = idx;
    bus.entryhi_i = hi; bus.entrylo0_i = lo0; bus.entrylo1_i = lo1;
  endtask

  task automatic expect_probe(input logic fail, input logic [3:0] idx);
    oq.push_back('{is_rd: 1'b0, a: {27'b0, fail, idx}, b: 32'h0, c: 32'h0});
  endtask

  task automatic expect_read(input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    oq.push_back('{is_rd: 1'b1, a: hi, b: lo0, c: lo1});
  endtask

  task automatic tick;
    lk_e e;
    op_e o;
    @(posedge clk);
    #1;
    check_eq("inst_valid", bus.inst_valid, iq.size() != 0);
    if (iq.size() != 0) begin
      e = iq.pop_front();
      if (bus.inst_valid) begin
        check_eq("inst_flags", {bus.inst_illegal, bus.inst_miss, bus.inst_inval, 1'b0, bus.inst_uncached}, e.flags);
        if (e.flags[4:1] == 4'b0) check_eq("inst_paddr", bus.inst_paddr, e.paddr);
      end
    end
    check_eq("data_valid", bus.data_valid, dq.size() != 0);
    if (dq.size() != 0) begin
      e = dq.pop_front();
      if (bus.data_valid) begin
        check_eq("data_flags", {bus.data_illegal, bus.data_miss, bus.data_inval, bus.data_modify, bus.data_uncached}, e.flags);
        if (e.flags[4:1] == 4'b0) check_eq("data_paddr", bus.data_paddr, e.paddr);
      end
    end
    check_eq("op_done", bus.tlb_op_done, oq.size() != 0);
    if (oq.size() != 0) begin
      o = oq.pop_front();
      if (bus.tlb_op_done && !o.is_rd) begin
        check_eq("probe", {27'b0, bus.probe_fail, bus.probe_index}, o.a);
      end else if (bus.tlb_op_done) begin
        check_eq("rd_hi", bus.entryhi_o, o.a);
        check_eq("rd_lo0", bus.entrylo0_o, o.b);
        check_eq("rd_lo1", bus.entrylo1_o, o.c);
      end
    end
    bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.data_we = 1'b0; bus.tlb_op_valid = 1'b0;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    bus.inst_req = 1'b0; bus.inst_vaddr = '0; bus.data_req = 1'b0; bus.data_vaddr = '0;
    bus.data_we = 1'b0; bus.user_mode = 1'b0; bus.cp0_kseg0_uncached = 1'b0; bus.asid = '0;
    bus.wired = '0; bus.tlb_op_valid = 1'b0; bus.tlb_op = '0; bus.index_i = '0;
    bus.entryhi_i = '0; bus.entrylo0_i = '0; bus.entrylo1_i = '0;
    tick();
    tick();
    check_eq("rst_random", bus.random_o, 4'd15);
    check_eq("rst_probe_fail", bus.probe_fail, 1'b0);
    check_eq("rst_entryhi", bus.entryhi_o, 32'h0);
    check_eq("rst_inst_paddr", bus.inst_paddr, 32'h0);
    rst = 1'b0;

    dreq(32'h0040_0000, 1'b0, F_MISS, 32'h0);
    ireq(32'hBFC0_0000, F_UC, 32'h1FC0_0000);
    tick();

    bus.asid = 8'd5;
    op(OP_WI, 4'd3, 32'h0040_0005, 32'h0048_D15A, 32'h0000_0000);
    tick();
    dreq(32'h0040_0ABC, 1'b0, F_OK, 32'h1234_5ABC);
    tick();
    dreq(32'h0040_0ABC, 1'b1, F_MOD, 32'h0);
    tick();
    dreq(32'h0040_1000, 1'b0, F_INV, 32'h0);
    tick();
    bus.asid = 8'd6;
    dreq(32'h0040_0ABC, 1'b0, F_MISS, 32'h0);
    tick();

    // global rewrite: lookup sampled with the write sees old entry, the next one sees new
    op(OP_WI, 4'd3, 32'h0040_0005, 32'h0048_D15B, 32'h0000_0001);
    dreq(32'h0040_0ABC, 1'b0, F_MISS, 32'h0);
    tick();
    dreq(32'h0040_0ABC, 1'b0, F_OK, 32'h1234_5ABC);
    tick();

    op(OP_P, 4'd0, 32'h0040_0006, 32'h0, 32'h0);
    expect_probe(1'b0, 4'd3);
    tick();
    op(OP_P, 4'd0, 32'h1234_0000, 32'h0, 32'h0);
    expect_probe(1'b1, 4'd0);
    tick();
    op(OP_R, 4'd3, 32'h0, 32'h0, 32'h0);
    expect_read(32'h0040_0005, 32'h0048_D15B, 32'h0000_0001);
    tick();

    bus.user_mode = 1'b1;
    ireq(32'h8000_0000, F_ILL, 32'h0);
    dreq(32'h0040_0ABC, 1'b0, F_OK, 32'h1234_5ABC);
    tick();
    bus.user_mode = 1'b0;
    ireq(32'h8000_1234, F_OK, 32'h0000_1234);
    tick();
    bus.cp0_kseg0_uncached = 1'b1;
    ireq(32'h8000_1234, F_UC, 32'h0000_1234);
    tick();
    bus.cp0_kseg0_uncached = 1'b0;

    bus.wired = 4'd12;
    waited = 0;
    while (bus.random_o != 4'd15 && waited < 20) begin
      tick();
      waited++;
    end
    check_eq("random_sync", bus.random_o, 4'd15);
    tick(); check_eq("random_14", bus.random_o, 4'd14);
    tick(); check_eq("random_13", bus.random_o, 4'd13);
    tick(); check_eq("random_12", bus.random_o, 4'd12);
    tick(); check_eq("random_wrap", bus.random_o, 4'd15);
    bus.asid = 8'd7;
    op(OP_WR, 4'd0, 32'h0080_2007, 32'h0002_AF16, 32'h0000_0000);
    tick();
    check_eq("random_reload", bus.random_o, 4'd15);
    op(OP_R, 4'd15, 32'h0, 32'h0, 32'h0);
    expect_read(32'h0080_2007, 32'h0002_AF16, 32'h0000_0000);
    dreq(32'h0080_2345, 1'b1, F_UC, 32'h00AB_C345);
    tick();

    // reset coinciding with a probe and a lookup drops both results
    rst = 1'b1;
    op(OP_P, 4'd0, 32'h0040_0006, 32'h0, 32'h0);
    bus.data_req = 1'b1; bus.data_vaddr = 32'h0040_0ABC;
    tick();
    check_eq("rst2_random", bus.random_o, 4'd15);
    check_eq("rst2_probe_fail", bus.probe_fail, 1'b0);
    check_eq("rst2_data_paddr", bus.data_paddr, 32'h0);
    rst = 1'b0;
    bus.wired = 4'd0;

    bus.asid = 8'd5;
    op(OP_P, 4'd0, 32'h0040_0006, 32'h0, 32'h0);
    expect_probe(1'b1, 4'd0);
    dreq(32'h0040_0ABC, 1'b0, F_MISS, 32'h0);
    tick();
    tick();
    check_eq("hold_data_miss", bus.data_miss, 1'b1);
    check_eq("drain", iq.size() + dq.size() + oq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
